// File: rtl/clk_div_gen_pkg.sv
// Shared types for the multi-channel clock divider: FSM state, per-channel config, legality check.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a. Optional duty-cycle control is enabled by CLK_DIV_GEN_DUTY_EN.
package clk_div_gen_pkg;

  // Width of the stored per-channel configuration fields; the top's CNT_W defaults to this.
  localparam int CFG_W = 16;

  typedef enum logic {
    SETTLE = 1'b0,
    LOCKED = 1'b1
  } state_t;

  typedef struct packed {
    logic [CFG_W-1:0] div;
    logic [CFG_W-1:0] phase;
`ifdef CLK_DIV_GEN_DUTY_EN
    logic [CFG_W-1:0] hi;
`endif
  } chan_cfg_t;

  // A request is legal when the divider can actually produce a period with the
  // phase inside it and the channel index exists.
  function automatic logic cfg_legal(
    input logic [CFG_W-1:0] div,
    input logic [CFG_W-1:0] phase,
`ifdef CLK_DIV_GEN_DUTY_EN
    input logic [CFG_W-1:0] hi,
`endif
    input int unsigned      ch,
    input int unsigned      num_ch
  );
    logic ok;
    ok = (div >= CFG_W'(2)) && (phase < div) && (ch < num_ch);
`ifdef CLK_DIV_GEN_DUTY_EN
    ok = ok && (hi >= CFG_W'(1)) && (hi < div);
`endif
    return ok;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: wrapping period counter plus registered outclk/tick.
// Latency: outputs reflect the count being loaded on the same edge (registered from next count).
// Backpressure: none; realign forces the counter to phase on the edge it is asserted.
module clk_div_chan #(
  parameter int CNT_W = 16
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             realign,
  input  logic [CNT_W-1:0] div,
  input  logic [CNT_W-1:0] phase,
  input  logic [CNT_W-1:0] hi,
  output logic             outclk,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;

  // Next count: realign jumps to the phase offset, otherwise wrap at div-1.
  // The >= guard keeps the counter bounded even if div ever shrinks under it.
  always_comb begin
    cnt_n = cnt + 1'b1;
    if (realign) begin
      cnt_n = phase;
    end else if (cnt >= div - 1'b1) begin
      cnt_n = '0;
    end
  end

  // Counter and outputs all register from the next count so they stay in step.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      outclk <= 1'b0;
      tick   <= 1'b0;
    end else begin
      cnt    <= cnt_n;
      outclk <= (cnt_n < hi);
      tick   <= (cnt_n == '0);
    end
  end

endmodule

// File: rtl/clk_div_gen.sv
// Multi-channel clock generator: NUM_CH divided clocks/ticks from refclk; any accepted config realigns all.
// Latency: config takes effect on the accept edge; locked reasserts LOCK_CYCLES edges later.
// Backpressure: cfg_ready only in LOCKED; requester holds cfg_valid. CLK_DIV_GEN_DUTY_EN adds cfg_hi.
module clk_div_gen
  import clk_div_gen_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = CFG_W,
  parameter int LOCK_CYCLES = 16,
  parameter int DEF_DIV     = 2,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              refclk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  input  logic [CNT_W-1:0]  cfg_phase,
`ifdef CLK_DIV_GEN_DUTY_EN
  input  logic [CNT_W-1:0]  cfg_hi,
`endif
  output logic              cfg_err,
  output logic [NUM_CH-1:0] outclk,
  output logic [NUM_CH-1:0] tick,
  output logic              locked
);

  localparam int SW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  state_t      state;
  logic [SW-1:0] settle_cnt;
  chan_cfg_t   cfg_q [NUM_CH];
  chan_cfg_t   cfg_d [NUM_CH];
  logic        hs;
  logic        legal;
  logic        accept;

  assign cfg_ready = (state == LOCKED);
  assign hs        = cfg_valid & cfg_ready;

  // Legality of the request currently on the bus.
  always_comb begin
    legal = cfg_legal(cfg_div, cfg_phase,
`ifdef CLK_DIV_GEN_DUTY_EN
                      cfg_hi,
`endif
                      32'(cfg_ch), NUM_CH);
  end

  assign accept = hs & legal;

  // Next configuration; channels see it on the accept edge so the realigned
  // count and outputs use the new divide/phase/high-time immediately.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      cfg_d[c] = cfg_q[c];
      if (accept && (int'(cfg_ch) == c)) begin
        cfg_d[c].div   = cfg_div;
        cfg_d[c].phase = cfg_phase;
`ifdef CLK_DIV_GEN_DUTY_EN
        cfg_d[c].hi    = cfg_hi;
`endif
      end
    end
  end

  // Configuration registers; reset restores the default ratio with zero phase.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cfg_q[c].div   <= CFG_W'(DEF_DIV);
        cfg_q[c].phase <= '0;
`ifdef CLK_DIV_GEN_DUTY_EN
        cfg_q[c].hi    <= CFG_W'(DEF_DIV >> 1);
`endif
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        cfg_q[c] <= cfg_d[c];
      end
    end
  end

  // Lock FSM: count out the settle window, then accept config; a legal config
  // drops back to SETTLE, an illegal one only pulses cfg_err.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state      <= SETTLE;
      settle_cnt <= '0;
      locked     <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      cfg_err <= 1'b0;
      case (state)
        SETTLE: begin
          if (settle_cnt == SW'(LOCK_CYCLES - 1)) begin
            state  <= LOCKED;
            locked <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        LOCKED: begin
          if (hs) begin
            if (legal) begin
              state      <= SETTLE;
              locked     <= 1'b0;
              settle_cnt <= '0;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        default: begin
          state <= SETTLE;
        end
      endcase
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [CNT_W-1:0] hi_c;
`ifdef CLK_DIV_GEN_DUTY_EN
    assign hi_c = cfg_d[c].hi;
`else
    // Odd ratios get the shorter half high.
    assign hi_c = cfg_d[c].div >> 1;
`endif
    clk_div_chan #(.CNT_W(CNT_W)) u_chan (
      .refclk  (refclk),
      .rst     (rst),
      .realign (accept),
      .div     (cfg_d[c].div),
      .phase   (cfg_d[c].phase),
      .hi      (hi_c),
      .outclk  (outclk[c]),
      .tick    (tick[c])
    );
  end

endmodule
